// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared widths, rounding offset and saturation helpers for the OS PE row
package pe_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_FRAC_BITS  = 8;
  localparam int DEFAULT_NUM_PE     = 4;
  localparam int DEFAULT_ACC_WIDTH  = 2 * DEFAULT_DATA_WIDTH + 8;
  localparam int MAX_WIDTH          = 64;

  typedef logic signed [MAX_WIDTH-1:0] wide_t;

  function automatic wide_t round_offset(input int frac_bits);
    return wide_t'(1) <<< (frac_bits - 1);
  endfunction

  function automatic wide_t saturate(input wide_t value, input int width);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/pe_row_os_if.sv
// rtl/pe_row_os_if.sv - operand, finish and result bundle of the OS PE row
interface pe_row_os_if #(
  parameter int DATA_WIDTH = pe_pkg::DEFAULT_DATA_WIDTH,
  parameter int NUM_PE     = pe_pkg::DEFAULT_NUM_PE
);
  logic [DATA_WIDTH-1:0]        i_left;
  logic                         i_left_valid;
  logic [NUM_PE*DATA_WIDTH-1:0] i_up;
  logic [NUM_PE-1:0]            i_up_valid;
  logic                         finish;
  logic [DATA_WIDTH-1:0]        o_right;
  logic                         o_right_valid;
  logic                         o_finish;
  logic [NUM_PE*DATA_WIDTH-1:0] o_down;
  logic [NUM_PE-1:0]            o_down_valid;
  logic [NUM_PE*DATA_WIDTH-1:0] o_result;
  logic [NUM_PE-1:0]            o_result_valid;

  modport master (
    output i_left, i_left_valid, i_up, i_up_valid, finish,
    input  o_right, o_right_valid, o_finish, o_down, o_down_valid, o_result, o_result_valid
  );

  modport slave (
    input  i_left, i_left_valid, i_up, i_up_valid, finish,
    output o_right, o_right_valid, o_finish, o_down, o_down_valid, o_result, o_result_valid
  );
endinterface

// File: rtl/pe_cell.sv
// rtl/pe_cell.sv - one output-stationary MAC cell; PE_SATURATE_EN clamps results instead of truncating
module pe_cell import pe_pkg::*; #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FRAC_BITS  = DEFAULT_FRAC_BITS,
  parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] left_i,
  input  logic                         left_valid_i,
  input  logic                         finish_i,
  input  logic signed [DATA_WIDTH-1:0] up_i,
  input  logic                         up_valid_i,
  output logic signed [DATA_WIDTH-1:0] right_o,
  output logic                         right_valid_o,
  output logic                         finish_o,
  output logic signed [DATA_WIDTH-1:0] down_o,
  output logic                         down_valid_o,
  output logic signed [DATA_WIDTH-1:0] result_o,
  output logic                         result_valid_o
);

  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] ROUND_OFS = ACC_WIDTH'(round_offset(FRAC_BITS));

  logic signed [DATA_WIDTH-1:0] right_q, down_q, result_q, result_d;
  logic                         right_valid_q, finish_q, down_valid_q, result_valid_q;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d, acc_sum, rounded;
  logic signed [PROD_WIDTH-1:0] product;
  wide_t                        rounded_wide, limited;
  logic                         unused_high_bits;

  // The result includes a product landing on the finish cycle itself.
  always_comb begin
    product = PROD_WIDTH'(left_i) * PROD_WIDTH'(up_i);
    acc_sum = acc_q;
    if (left_valid_i && up_valid_i) begin
      acc_sum = acc_q + ACC_WIDTH'(product);
    end
    rounded      = (acc_sum + ROUND_OFS) >>> FRAC_BITS;
    rounded_wide = MAX_WIDTH'(rounded);
`ifdef PE_SATURATE_EN
    limited = saturate(rounded_wide, DATA_WIDTH);
`else
    limited = rounded_wide;
`endif
    result_d = limited[DATA_WIDTH-1:0];
    acc_d    = finish_i ? '0 : acc_sum;
  end

  assign unused_high_bits = ^limited[MAX_WIDTH-1:DATA_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      right_q        <= '0;
      right_valid_q  <= 1'b0;
      finish_q       <= 1'b0;
      down_q         <= '0;
      down_valid_q   <= 1'b0;
      acc_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      right_q        <= left_i;
      right_valid_q  <= left_valid_i;
      finish_q       <= finish_i;
      down_q         <= up_i;
      down_valid_q   <= up_valid_i;
      acc_q          <= acc_d;
      result_valid_q <= finish_i;
      if (finish_i) begin
        result_q <= result_d;
      end
    end
  end

  assign right_o        = right_q;
  assign right_valid_o  = right_valid_q;
  assign finish_o       = finish_q;
  assign down_o         = down_q;
  assign down_valid_o   = down_valid_q;
  assign result_o       = result_q;
  assign result_valid_o = result_valid_q;

endmodule

// File: rtl/pe_row_os.sv
// rtl/pe_row_os.sv - row of NUM_PE output-stationary cells chained along the left stream
module pe_row_os import pe_pkg::*; #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FRAC_BITS  = DEFAULT_FRAC_BITS,
  parameter int NUM_PE     = DEFAULT_NUM_PE,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH + 8
) (
  input logic         clk,
  input logic         rst_n,
  pe_row_os_if.slave  bus
);

  logic signed [DATA_WIDTH-1:0] left_chain   [NUM_PE+1];
  logic                         valid_chain  [NUM_PE+1];
  logic                         finish_chain [NUM_PE+1];
  logic signed [DATA_WIDTH-1:0] down_arr     [NUM_PE];
  logic signed [DATA_WIDTH-1:0] result_arr   [NUM_PE];
  logic [NUM_PE-1:0]            down_valid_vec, result_valid_vec;

  assign left_chain[0]   = bus.i_left;
  assign valid_chain[0]  = bus.i_left_valid;
  assign finish_chain[0] = bus.finish;

  for (genvar k = 0; k < NUM_PE; k++) begin : g_cell
    pe_cell #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_cell (
      .clk            (clk),
      .rst_n          (rst_n),
      .left_i         (left_chain[k]),
      .left_valid_i   (valid_chain[k]),
      .finish_i       (finish_chain[k]),
      .up_i           (bus.i_up[k*DATA_WIDTH +: DATA_WIDTH]),
      .up_valid_i     (bus.i_up_valid[k]),
      .right_o        (left_chain[k+1]),
      .right_valid_o  (valid_chain[k+1]),
      .finish_o       (finish_chain[k+1]),
      .down_o         (down_arr[k]),
      .down_valid_o   (down_valid_vec[k]),
      .result_o       (result_arr[k]),
      .result_valid_o (result_valid_vec[k])
    );
  end

  always_comb begin
    bus.o_down   = '0;
    bus.o_result = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      bus.o_down[k*DATA_WIDTH +: DATA_WIDTH]   = down_arr[k];
      bus.o_result[k*DATA_WIDTH +: DATA_WIDTH] = result_arr[k];
    end
  end

  assign bus.o_down_valid   = down_valid_vec;
  assign bus.o_result_valid = result_valid_vec;
  assign bus.o_right        = left_chain[NUM_PE];
  assign bus.o_right_valid  = valid_chain[NUM_PE];
  assign bus.o_finish       = finish_chain[NUM_PE];

endmodule

// File: tb/tb_pe_row_os.sv
// tb/tb_pe_row_os.sv - directed self-checking bench for pe_row_os (NUM_PE=1 and NUM_PE=4 rows)
module tb_pe_row_os;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pe_row_os_if #(.DATA_WIDTH(16), .NUM_PE(1)) bus1 ();
  pe_row_os_if #(.DATA_WIDTH(16), .NUM_PE(4)) bus4 ();

  pe_row_os #(.DATA_WIDTH(16), .FRAC_BITS(8), .NUM_PE(1), .ACC_WIDTH(40)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  pe_row_os #(.DATA_WIDTH(16), .FRAC_BITS(8), .NUM_PE(4), .ACC_WIDTH(40)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic [15:0] l, input logic lv, input logic [15:0] u,
                        input logic uv, input logic fin);
    bus1.i_left       = l;
    bus1.i_left_valid = lv;
    bus1.i_up         = u;
    bus1.i_up_valid   = uv;
    bus1.finish       = fin;
  endtask

  logic [15:0] sat_expect;
  logic [3:0]  exp_valid;

  initial begin
`ifdef PE_SATURATE_EN
    sat_expect = 16'h7FFF;
`else
    sat_expect = 16'hFF00;
`endif
    rst_n = 1'b0;
    drive1(16'd0, 1'b0, 16'd0, 1'b0, 1'b0);
    bus4.i_left = '0; bus4.i_left_valid = 1'b0; bus4.i_up = '0;
    bus4.i_up_valid = '0; bus4.finish = 1'b0;
    tick();
    tick();
    check("reset_result",       64'(bus1.o_result),       64'd0);
    check("reset_result_valid", 64'(bus1.o_result_valid), 64'd0);
    check("reset_right",        64'(bus1.o_right),        64'd0);
    check("reset_row4_result",  64'(bus4.o_result),       64'd0);
    rst_n = 1'b1;

    // (20,100) then (40,100)+finish: 6000 -> 23
    drive1(16'd20, 1'b1, 16'd100, 1'b1, 1'b0);
    tick();
    check("first_no_valid", 64'(bus1.o_result_valid), 64'd0);
    check("right_fwd",      64'(bus1.o_right),        64'd20);
    check("right_valid",    64'(bus1.o_right_valid),  64'd1);
    check("down_fwd",       64'(bus1.o_down),         64'd100);
    check("down_valid",     64'(bus1.o_down_valid),   64'd1);
    drive1(16'd40, 1'b1, 16'd100, 1'b1, 1'b1);
    tick();
    check("mac_result",     64'(bus1.o_result),       64'd23);
    check("mac_valid",      64'(bus1.o_result_valid), 64'd1);
    check("mac_finish_out", 64'(bus1.o_finish),       64'd1);
    drive1(16'd0, 1'b0, 16'd0, 1'b0, 1'b0);
    tick();
    check("strobe_one_cycle", 64'(bus1.o_result_valid), 64'd0);
    check("result_hold",      64'(bus1.o_result),       64'd23);

    // half-up rounding: 384 -> 2, -384 -> -1
    drive1(16'd384, 1'b1, 16'd1, 1'b1, 1'b0);
    tick();
    drive1(16'd0, 1'b0, 16'd0, 1'b0, 1'b1);
    tick();
    check("round_pos", 64'(bus1.o_result), 64'd2);
    drive1(16'hFE80, 1'b1, 16'd1, 1'b1, 1'b0);
    tick();
    drive1(16'd0, 1'b0, 16'd0, 1'b0, 1'b1);
    tick();
    check("round_neg", 64'(bus1.o_result), 64'hFFFF);

    // overflow of the result width
    drive1(16'h7FFF, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    tick();
    check("overflow_result", 64'(bus1.o_result), 64'(sat_expect));

    // finish with no products
    drive1(16'd0, 1'b0, 16'd0, 1'b0, 1'b1);
    tick();
    check("empty_result", 64'(bus1.o_result),       64'd0);
    check("empty_valid",  64'(bus1.o_result_valid), 64'd1);

    // back-to-back finish, product 512 each
    drive1(16'd512, 1'b1, 16'd1, 1'b1, 1'b1);
    tick();
    check("b2b_first",       64'(bus1.o_result),       64'd2);
    check("b2b_first_valid", 64'(bus1.o_result_valid), 64'd1);
    tick();
    check("b2b_second",       64'(bus1.o_result),       64'd2);
    check("b2b_second_valid", 64'(bus1.o_result_valid), 64'd1);
    drive1(16'd0, 1'b0, 16'd0, 1'b0, 1'b0);
    tick();

    // reset mid-tile after three products
    drive1(16'd256, 1'b1, 16'd1, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    check("rst_async_result", 64'(bus1.o_result),       64'd0);
    check("rst_async_right",  64'(bus1.o_right),        64'd0);
    check("rst_async_rvalid", 64'(bus1.o_right_valid),  64'd0);
    check("rst_async_down",   64'(bus1.o_down),         64'd0);
    check("rst_async_dvalid", 64'(bus1.o_down_valid),   64'd0);
    tick();
    check("rst_held_valid",   64'(bus1.o_result_valid), 64'd0);
    rst_n = 1'b1;
    drive1(16'd256, 1'b1, 16'd1, 1'b1, 1'b1);
    tick();
    check("rst_resume_result", 64'(bus1.o_result),       64'd1);
    check("rst_resume_valid",  64'(bus1.o_result_valid), 64'd1);
    drive1(16'd0, 1'b0, 16'd0, 1'b0, 1'b0);

    // four-cell row: left=256 with finish for one cycle, all up=1
    bus4.i_up         = {4{16'd1}};
    bus4.i_up_valid   = 4'hF;
    bus4.i_left       = 16'd256;
    bus4.i_left_valid = 1'b1;
    bus4.finish       = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      tick();
      if (t == 1) begin
        bus4.i_left = '0; bus4.i_left_valid = 1'b0; bus4.finish = 1'b0;
      end
      exp_valid = (t <= 4) ? 4'(1 << (t - 1)) : 4'd0;
      check($sformatf("row4_valid_t%0d", t),  64'(bus4.o_result_valid), 64'(exp_valid));
      check($sformatf("row4_finish_t%0d", t), 64'(bus4.o_finish),       64'(t == 4));
      if (t <= 4) begin
        check($sformatf("row4_result_cell%0d", t - 1),
              64'(bus4.o_result[(t-1)*16 +: 16]), 64'd1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
